// File: rtl/i2s_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2s_tx -- I2S master transmitter
//
// Accepts left/right sample pairs over a valid/ready handshake. BCK and LRCK
// are derived from MCLK by integer division. Each pair is sent as a standard
// I2S frame: two 32-bit slots, MSB first, with data one BCK after the LRCK
// edge. LRCK is low for the left slot. Samples are left-aligned in their
// slots and the unused LSBs are zero.
//
// Parameters
//   DIV    MCLK cycles per BCK half-period (>= 1)
//   WIDTH  sample width in bits (1..32)
//
// Ports
//   i_mclk      master clock; all registers update on its rising edge
//   i_resetn    synchronous active-low reset
//   i_l_data    left sample (two's complement)
//   i_r_data    right sample (two's complement)
//   i_valid     a sample pair is offered
//   o_ready     holding buffer empty; a pair is taken when i_valid & o_ready
//   o_bck       bit clock
//   o_lrck      word clock (0 = left slot, 1 = right slot)
//   o_dataout   serial data; changes only when BCK falls
//   o_underrun  one-cycle pulse when a frame starts with no pair buffered
//
// Build option
//   I2S_TX_HOLD_LAST_EN  when defined, an underrun repeats the last pair that
//                        was loaded. Otherwise an underrun sends zeros.
// ---------------------------------------------------------------------------
module i2s_tx #(
  parameter int DIV   = 2,
  parameter int WIDTH = 24
) (
  input  logic             i_mclk,
  input  logic             i_resetn,
  input  logic [WIDTH-1:0] i_l_data,
  input  logic [WIDTH-1:0] i_r_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_bck,
  output logic             o_lrck,
  output logic             o_dataout,
  output logic             o_underrun
);

  localparam int            DW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DIV - 1);
  localparam int            PAD       = 32 - WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_hb_l;
  logic [WIDTH-1:0] r_hb_r;
  logic             r_hb_full;
  logic [63:0]      r_sr;
  logic [5:0]       r_bcnt;
  logic [DW-1:0]    r_dcnt;
  logic             r_bck;
  logic             r_lrck;
  logic             r_dataout;
  logic             r_underrun;

  logic             w_tick;
  logic             w_fall;
  logic             w_load;
  logic             w_accept;
  logic [5:0]       w_bcnt_inc;
  logic [63:0]      w_frame_hb;
  logic [63:0]      w_frame_fill;

  // Place a sample left-aligned in a 32-bit slot. A shift is used instead of
  // a zero-replication so that WIDTH = 32 (no padding) stays legal.
  function automatic logic [31:0] slot(input logic [WIDTH-1:0] s);
    return 32'(s) << PAD;
  endfunction

  // -------------------------------------------------------------------------
  // Control FSM: IDLE holds the outputs static until the first pair is
  // buffered. RUN lasts until the next reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_mclk) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_hb_full) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_tick = (r_dcnt == DCNT_LAST);
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // A tick taken while BCK is high is a falling event. A frame boundary is
  // the falling event that wraps BCNT from 63 to 0.
  assign w_fall     = w_tick & r_bck;
  assign w_load     = w_fall & (r_bcnt == 6'd63);
  assign w_accept   = i_valid & ~r_hb_full;
  assign w_bcnt_inc = r_bcnt + 6'd1;
  assign w_frame_hb = {slot(r_hb_l), slot(r_hb_r)};

`ifdef I2S_TX_HOLD_LAST_EN
  logic [WIDTH-1:0] r_last_l;
  logic [WIDTH-1:0] r_last_r;

  always_ff @(posedge i_mclk) begin
    if (!i_resetn) begin
      r_last_l <= '0;
      r_last_r <= '0;
    end else if (w_load && r_hb_full) begin
      r_last_l <= r_hb_l;
      r_last_r <= r_hb_r;
    end
  end

  assign w_frame_fill = {slot(r_last_l), slot(r_last_r)};
`else
  assign w_frame_fill = '0;
`endif

  // -------------------------------------------------------------------------
  // Datapath: divider, bit counter, shift register and holding buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge i_mclk) begin
    if (!i_resetn) begin
      r_hb_l     <= '0;
      r_hb_r     <= '0;
      r_hb_full  <= 1'b0;
      r_sr       <= '0;
      r_bcnt     <= 6'd63;
      r_dcnt     <= '0;
      r_bck      <= 1'b0;
      r_lrck     <= 1'b1;
      r_dataout  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;

      if (r_state == S_RUN) begin
        if (w_tick) begin
          r_dcnt <= '0;
          r_bck  <= ~r_bck;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end

      if (w_fall) begin
        r_bcnt    <= w_bcnt_inc;
        r_lrck    <= w_bcnt_inc[5];
        // The outgoing bit is taken before the shift or reload. Because of
        // that, the slot-0 position of each frame still carries the previous
        // frame's right LSB.
        r_dataout <= r_sr[63];
        if (w_load) begin
          r_sr       <= r_hb_full ? w_frame_hb : w_frame_fill;
          r_underrun <= ~r_hb_full;
        end else begin
          r_sr <= {r_sr[62:0], 1'b0};
        end
      end

      // A pair accepted on a load edge can only arrive while the buffer is
      // empty. It is therefore kept for the next frame, not the current one.
      if (w_accept) begin
        r_hb_l    <= i_l_data;
        r_hb_r    <= i_r_data;
        r_hb_full <= 1'b1;
      end else if (w_load) begin
        r_hb_full <= 1'b0;
      end
    end
  end

  assign o_ready    = ~r_hb_full;
  assign o_bck      = r_bck;
  assign o_lrck     = r_lrck;
  assign o_dataout  = r_dataout;
  assign o_underrun = r_underrun;

endmodule
